// File: rtl/aeolus_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Package  : aeolus_pkg
// Purpose  : shared types and encodings for the Aeolus sequencer and decoder
// Revision : 1.0
// ----------------------------------------------------------------------------
package aeolus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_ADVANCE = 3'd4
    } state_t;

    // Numbering is shared with the instruction decoder; do not reorder.
    typedef enum logic [3:0] {
        OPC_LDA  = 4'd0,
        OPC_LDI  = 4'd1,
        OPC_STA  = 4'd2,
        OPC_LDS  = 4'd3,
        OPC_STS  = 4'd4,
        OPC_INC  = 4'd5,
        OPC_DEC  = 4'd6,
        OPC_NOP  = 4'd7,
        OPC_SNZA = 4'd8,
        OPC_SNZS = 4'd9,
        OPC_ADD  = 4'd10,
        OPC_SUB  = 4'd11,
        OPC_AND  = 4'd12,
        OPC_OR   = 4'd13,
        OPC_XOR  = 4'd14,
        OPC_INV  = 4'd15
    } opcode_t;

    localparam logic [3:0] OP_SNZA = 4'h8;
    localparam logic [3:0] OP_SNZS = 4'h9;

    localparam logic [1:0] PH_IDLE    = 2'd0;
    localparam logic [1:0] PH_FETCH   = 2'd1;
    localparam logic [1:0] PH_DECODE  = 2'd2;
    localparam logic [1:0] PH_EXECUTE = 2'd3;

    // A skip instruction jumps over the next word when its flag is clear.
    function automatic logic is_skip(input logic [3:0] op,
                                     input logic       zero_a,
                                     input logic       zero_s);
        return ((op == OP_SNZA) && !zero_a) || ((op == OP_SNZS) && !zero_s);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aeolus_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Interface: aeolus_sequencer_if
// Purpose  : ROM fetch port and decoder/datapath handshake of the sequencer
// Revision : 1.0
// ----------------------------------------------------------------------------
interface aeolus_sequencer_if #(
    parameter int PC_WIDTH = 8
);
    logic [PC_WIDTH-1:0] rom_addr;
    logic [7:0]          rom_data;
    logic                zero_a;
    logic                zero_s;
    logic [3:0]          opcode;
    logic [3:0]          operand;
    logic                exec_en;

    modport master (
        output rom_addr, opcode, operand, exec_en,
        input  rom_data, zero_a, zero_s
    );

    modport slave (
        input  rom_addr, opcode, operand, exec_en,
        output rom_data, zero_a, zero_s
    );
endinterface
`default_nettype wire

// File: rtl/aeolus_pc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : aeolus_pc
// Purpose  : program counter with sync active-low clear and +1/+2 advance
// Revision : 1.0
// ----------------------------------------------------------------------------
module aeolus_pc #(
    parameter int PC_WIDTH = 8
) (
    input  wire logic                CLKin,
    input  wire logic                reset,
    input  wire logic                en,
    input  wire logic                inc2,
    output logic      [PC_WIDTH-1:0] pc
);
    localparam logic [PC_WIDTH-1:0] c_inc_one = PC_WIDTH'(1);
    localparam logic [PC_WIDTH-1:0] c_inc_two = PC_WIDTH'(2);

    logic [PC_WIDTH-1:0] r_pc;

    // Natural modulo-2^PC_WIDTH wrap is the intended behaviour.
    always_ff @(posedge CLKin) begin
        if (!reset) begin
            r_pc <= '0;
        end else if (en) begin
            r_pc <= r_pc + (inc2 ? c_inc_two : c_inc_one);
        end
    end

    assign pc = r_pc;
endmodule
`default_nettype wire

// File: rtl/aeolus_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : aeolus_sequencer
// Purpose  : fetch/decode/execute controller with skip, run and single-step
// Revision : 1.0
// ----------------------------------------------------------------------------
module aeolus_sequencer
    import aeolus_pkg::*;
#(
    parameter int PC_WIDTH  = 8,
    parameter int CNT_WIDTH = 16
) (
    input  wire logic                 CLKin,
    input  wire logic                 reset,
    input  wire logic                 run,
    input  wire logic                 step,
    aeolus_sequencer_if.master        bus,
    output logic      [PC_WIDTH-1:0]  pc,
    output logic      [1:0]           phase,
    output logic                      halted,
    output logic      [CNT_WIDTH-1:0] retired
);
    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_step_q;
    logic                 r_skip_q;
    logic [3:0]           r_opcode;
    logic [3:0]           r_operand;
    logic [CNT_WIDTH-1:0] r_retired;
    logic [PC_WIDTH-1:0]  w_pc;
    logic                 w_step_rise;
    logic                 w_exec_en;
    logic                 w_advance;
    logic                 w_halted;
    logic [1:0]           w_phase;

    assign w_step_rise = step & ~r_step_q;

    always_ff @(posedge CLKin) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // run dropping mid-instruction is only consulted at ADVANCE, so an
    // instruction in flight always completes.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (run || w_step_rise) w_state_nxt = ST_FETCH;
            ST_FETCH:   w_state_nxt = ST_DECODE;
            ST_DECODE:  w_state_nxt = ST_EXECUTE;
            ST_EXECUTE: w_state_nxt = ST_ADVANCE;
            ST_ADVANCE: w_state_nxt = run ? ST_FETCH : ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_exec_en = 1'b0;
        w_advance = 1'b0;
        w_halted  = 1'b0;
        w_phase   = PH_IDLE;
        case (r_state)
            ST_IDLE:    w_halted = 1'b1;
            ST_FETCH:   w_phase  = PH_FETCH;
            ST_DECODE:  w_phase  = PH_DECODE;
            ST_EXECUTE: begin
                w_phase   = PH_EXECUTE;
                w_exec_en = 1'b1;
            end
            ST_ADVANCE: begin
                w_phase   = PH_EXECUTE;
                w_advance = 1'b1;
            end
            default:    w_halted = 1'b1;
        endcase
    end

    // IR, skip flag, step edge history and retired counter.
    always_ff @(posedge CLKin) begin
        if (!reset) begin
            r_step_q  <= 1'b0;
            r_skip_q  <= 1'b0;
            r_opcode  <= 4'd0;
            r_operand <= 4'd0;
            r_retired <= '0;
        end else begin
            r_step_q <= step;
            if (r_state == ST_DECODE) begin
                r_opcode  <= bus.rom_data[7:4];
                r_operand <= bus.rom_data[3:0];
            end
            if (w_exec_en) begin
                r_skip_q <= is_skip(r_opcode, bus.zero_a, bus.zero_s);
            end
            if (w_advance) begin
                r_retired <= r_retired + CNT_WIDTH'(1);
            end
        end
    end

    aeolus_pc #(
        .PC_WIDTH (PC_WIDTH)
    ) u_pc (
        .CLKin (CLKin),
        .reset (reset),
        .en    (w_advance),
        .inc2  (r_skip_q),
        .pc    (w_pc)
    );

    assign bus.rom_addr = w_pc;
    assign bus.opcode   = r_opcode;
    assign bus.operand  = r_operand;
    assign bus.exec_en  = w_exec_en;
    assign pc           = w_pc;
    assign phase        = w_phase;
    assign halted       = w_halted;
    assign retired      = r_retired;
endmodule
`default_nettype wire

// File: tb/tb_aeolus_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_aeolus_sequencer
// Purpose  : self-checking bench with an instruction-level reference model
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_aeolus_sequencer;
    logic        CLKin = 1'b0;
    logic        reset = 1'b0;
    logic        run   = 1'b0;
    logic        step  = 1'b0;
    logic [7:0]  pc;
    logic [1:0]  phase;
    logic        halted;
    logic [15:0] retired;
    logic [7:0]  mem [0:255];
    int          vectors     = 0;
    int          miscompares = 0;

    aeolus_sequencer_if #(.PC_WIDTH(8)) bus ();

    aeolus_sequencer #(.PC_WIDTH(8), .CNT_WIDTH(16)) dut (
        .CLKin   (CLKin),
        .reset   (reset),
        .run     (run),
        .step    (step),
        .bus     (bus),
        .pc      (pc),
        .phase   (phase),
        .halted  (halted),
        .retired (retired)
    );

    always #5 CLKin = ~CLKin;

    // Synchronous ROM: word appears the cycle after its address.
    always @(posedge CLKin) bus.rom_data <= mem[bus.rom_addr];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: next pc from the instruction word and the flags it sees.
    function automatic logic [7:0] model_next_pc(input logic [7:0] p, input logic [7:0] word,
                                                 input logic za, input logic zs);
        int adv;
        adv = 1;
        if ((word[7:4] == 4'd8 && !za) || (word[7:4] == 4'd9 && !zs)) adv = 2;
        return 8'((int'(p) + adv) % 256);
    endfunction

    task automatic fill_mem(input logic [7:0] word);
        for (int i = 0; i < 256; i++) mem[i] = word;
    endtask

    task automatic do_reset();
        @(negedge CLKin);
        reset = 1'b0; run = 1'b0; step = 1'b0;
        repeat (2) @(negedge CLKin);
        reset = 1'b1;
        @(negedge CLKin);
    endtask

    task automatic wait_exec(input int budget, output int cycles, output bit ok);
        ok = 1'b0; cycles = 0;
        while (!ok && cycles < budget) begin
            @(negedge CLKin);
            cycles++;
            if (bus.exec_en === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic advance_to(input logic [7:0] target, input int budget, output bit ok);
        int n;
        ok = 1'b0; n = 0;
        while (!ok && n < budget) begin
            @(negedge CLKin);
            n++;
            if (bus.exec_en === 1'b1 && pc === target) ok = 1'b1;
        end
    endtask

    task automatic wait_halt(input int budget, output bit ok);
        int n;
        ok = 1'b0; n = 0;
        while (!ok && n < budget) begin
            @(negedge CLKin);
            n++;
            if (halted === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        bit ok;
        fill_mem(8'h70);
        @(negedge CLKin);
        reset = 1'b0; run = 1'b1; step = 1'b0;
        repeat (3) @(negedge CLKin);
        vectors++;
        if ({pc, halted, bus.exec_en, phase, retired, bus.opcode, bus.operand, bus.rom_addr} !==
            {8'h00, 1'b1, 1'b0, 2'd0, 16'd0, 4'd0, 4'd0, 8'h00}) begin
            miscompares++;
            $display("FAIL reset_hold: pc=%0h halted=%0b exec=%0b phase=%0d ret=%0d, required 0/1/0/0/0",
                     pc, halted, bus.exec_en, phase, retired);
        end
        reset = 1'b1;
        @(negedge CLKin);
        vectors++;
        if (phase !== 2'd1) begin
            miscompares++; $display("FAIL release_fetch: phase=%0d required 1", phase);
        end
        repeat (2) @(negedge CLKin);
        vectors++;
        if ({bus.exec_en, phase} !== {1'b1, 2'd3}) begin
            miscompares++;
            $display("FAIL first_exec: exec=%0b phase=%0d required 1/3", bus.exec_en, phase);
        end
        repeat (2) @(negedge CLKin);
        vectors++;
        if ({pc, phase, retired} !== {8'h01, 2'd1, 16'd1}) begin
            miscompares++;
            $display("FAIL first_advance: pc=%0h phase=%0d ret=%0d required 1/1/1", pc, phase, retired);
        end
        run = 1'b0;
        wait_halt(10, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL reset_halt: halted=%0b required 1", halted); end
    endtask

    task automatic test_free_run();
        logic [3:0] ops [4] = '{4'h0, 4'hA, 4'hB, 4'hE};
        bit ok;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) mem[i] = {ops[i], 4'($urandom)};
        bus.zero_a = 1'($urandom); bus.zero_s = 1'($urandom);
        do_reset();
        run = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            @(negedge CLKin);
            if (i <= 16) begin
                vectors++;
                if (bus.exec_en !== ((i % 4) == 3)) begin
                    miscompares++;
                    $display("FAIL freerun_exec_c%0d: exec=%0b required %0b", i, bus.exec_en, (i % 4) == 3);
                end
                if ((i % 4) == 3) begin
                    vectors++;
                    if ({bus.opcode, bus.operand} !== mem[(i - 3) / 4]) begin
                        miscompares++;
                        $display("FAIL freerun_ir%0d: ir=%0h required %0h", (i - 3) / 4,
                                 {bus.opcode, bus.operand}, mem[(i - 3) / 4]);
                    end
                end
            end else begin
                vectors++;
                if ({retired, pc} !== {16'd4, 8'h04}) begin
                    miscompares++;
                    $display("FAIL freerun_retired: ret=%0d pc=%0h required 4/4", retired, pc);
                end
            end
        end
        run = 1'b0;
        wait_halt(10, ok);
    endtask

    task automatic test_random_program();
        logic [7:0] m_pc;
        int         m_ret;
        int         cyc;
        bit         ok;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        bus.zero_a = 1'($urandom); bus.zero_s = 1'($urandom);
        do_reset();
        m_pc = 8'h00; m_ret = 0;
        run = 1'b1;
        for (int k = 0; k < 40; k++) begin
            wait_exec(8, cyc, ok);
            vectors++;
            if (!ok || cyc != (k == 0 ? 3 : 2)) begin
                miscompares++;
                $display("FAIL rand_timing%0d: waited %0d cycles (seen=%0b) required %0d", k, cyc, ok,
                         (k == 0 ? 3 : 2));
                break;
            end
            vectors++;
            if ({bus.opcode, bus.operand, pc} !== {mem[m_pc], m_pc}) begin
                miscompares++;
                $display("FAIL rand_ir%0d: ir=%0h pc=%0h required %0h/%0h", k,
                         {bus.opcode, bus.operand}, pc, mem[m_pc], m_pc);
            end
            m_pc = model_next_pc(m_pc, mem[m_pc], bus.zero_a, bus.zero_s);
            m_ret++;
            @(negedge CLKin);
            bus.zero_a = 1'($urandom); bus.zero_s = 1'($urandom);
            @(negedge CLKin);
            vectors++;
            if ({phase, pc, retired} !== {2'd1, m_pc, 16'(m_ret)}) begin
                miscompares++;
                $display("FAIL rand_next%0d: phase=%0d pc=%0h ret=%0d required 1/%0h/%0d", k,
                         phase, pc, retired, m_pc, m_ret);
            end
        end
        run = 1'b0;
        wait_halt(10, ok);
    endtask

    task automatic test_skip();
        logic [3:0] c_op [4] = '{4'h8, 4'h8, 4'h9, 4'h9};
        logic       c_za [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic       c_zs [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [7:0] c_pc [4] = '{8'd7, 8'd6, 8'd7, 8'd6};
        bit ok;
        for (int c = 0; c < 4; c++) begin
            fill_mem(8'h70);
            mem[5] = {c_op[c], 4'($urandom)};
            do_reset();
            bus.zero_a = c_za[c]; bus.zero_s = c_zs[c];
            run = 1'b1;
            advance_to(8'd5, 60, ok);
            repeat (2) @(negedge CLKin);
            vectors++;
            if (!ok || pc !== c_pc[c]) begin
                miscompares++;
                $display("FAIL skip_case%0d: pc=%0h (reached=%0b) required %0h", c, pc, ok, c_pc[c]);
            end
            run = 1'b0;
            wait_halt(10, ok);
        end
    endtask

    task automatic test_single_step();
        int n;
        int cyc;
        bit ok;
        for (int i = 0; i < 256; i++) mem[i] = {4'h1, 4'($urandom)};
        do_reset();
        step = 1'b1;
        n = 0;
        repeat (20) begin @(negedge CLKin); if (bus.exec_en === 1'b1) n++; end
        vectors++;
        if (n != 1 || {halted, pc, retired} !== {1'b1, 8'h01, 16'd1}) begin
            miscompares++;
            $display("FAIL step_held: execs=%0d halted=%0b pc=%0h ret=%0d required 1/1/1/1",
                     n, halted, pc, retired);
        end
        step = 1'b0;
        repeat (2) @(negedge CLKin);
        step = 1'b1;
        n = 0;
        repeat (12) begin @(negedge CLKin); if (bus.exec_en === 1'b1) n++; end
        vectors++;
        if (n != 1 || {halted, pc, retired} !== {1'b1, 8'h02, 16'd2}) begin
            miscompares++;
            $display("FAIL step_again: execs=%0d halted=%0b pc=%0h ret=%0d required 1/1/2/2",
                     n, halted, pc, retired);
        end
        step = 1'b0;
        @(negedge CLKin);
        run = 1'b1; step = 1'b1;
        wait_exec(8, cyc, ok);
        n = 0;
        repeat (8) begin @(negedge CLKin); if (bus.exec_en === 1'b1) n++; end
        vectors++;
        if (!ok || n != 2) begin
            miscompares++;
            $display("FAIL step_with_run: execs=%0d (first seen=%0b) required 2", n, ok);
        end
        run = 1'b0; step = 1'b0;
        wait_halt(10, ok);
    endtask

    task automatic test_pc_wrap();
        bit ok;
        fill_mem(8'h70);
        mem[8'hFE] = {4'h9, 4'($urandom)};
        mem[8'hFF] = {4'hA, 4'($urandom)};
        do_reset();
        bus.zero_a = 1'b1; bus.zero_s = 1'b0;
        run = 1'b1;
        advance_to(8'hFE, 1200, ok);
        repeat (2) @(negedge CLKin);
        vectors++;
        if (!ok || {phase, pc} !== {2'd1, 8'h00}) begin
            miscompares++;
            $display("FAIL wrap_fe_skip: pc=%0h (reached=%0b) required 00", pc, ok);
        end
        bus.zero_s = 1'b1;
        advance_to(8'hFE, 1200, ok);
        repeat (2) @(negedge CLKin);
        advance_to(8'hFF, 8, ok);
        vectors++;
        if (!ok || bus.opcode !== 4'hA) begin
            miscompares++;
            $display("FAIL wrap_ff_fetch: op=%0h (reached=%0b) required a", bus.opcode, ok);
        end
        repeat (2) @(negedge CLKin);
        vectors++;
        if (pc !== 8'h00) begin
            miscompares++; $display("FAIL wrap_ff_noskip: pc=%0h required 00", pc);
        end
        mem[8'hFF] = {4'h8, 4'($urandom)};
        bus.zero_a = 1'b0;
        advance_to(8'hFF, 1200, ok);
        repeat (2) @(negedge CLKin);
        vectors++;
        if (!ok || pc !== 8'h01) begin
            miscompares++;
            $display("FAIL wrap_ff_skip: pc=%0h (reached=%0b) required 01", pc, ok);
        end
        run = 1'b0;
        wait_halt(10, ok);
    endtask

    task automatic test_reset_mid();
        int cyc;
        int n;
        bit ok;
        fill_mem(8'h70);
        do_reset();
        run = 1'b1;
        for (int k = 0; k < 3; k++) wait_exec(8, cyc, ok);
        reset = 1'b0;
        @(negedge CLKin);
        vectors++;
        if (!ok || {bus.exec_en, pc, retired, halted, phase} !== {1'b0, 8'h00, 16'd0, 1'b1, 2'd0}) begin
            miscompares++;
            $display("FAIL reset_mid: exec=%0b pc=%0h ret=%0d halted=%0b phase=%0d required 0/0/0/1/0",
                     bus.exec_en, pc, retired, halted, phase);
        end
        reset = 1'b1; run = 1'b0;
        n = 0;
        repeat (6) begin @(negedge CLKin); if (bus.exec_en === 1'b1) n++; end
        vectors++;
        if (n != 0 || halted !== 1'b1) begin
            miscompares++; $display("FAIL reset_mid_quiet: execs=%0d halted=%0b required 0/1", n, halted);
        end
    endtask

    task automatic test_run_drop();
        int n;
        fill_mem(8'h70);
        do_reset();
        run = 1'b1;
        repeat (2) @(negedge CLKin);
        vectors++;
        if (phase !== 2'd2) begin
            miscompares++; $display("FAIL drop_decode: phase=%0d required 2", phase);
        end
        run = 1'b0;
        @(negedge CLKin);
        vectors++;
        if (bus.exec_en !== 1'b1) begin
            miscompares++; $display("FAIL drop_exec: exec=%0b required 1", bus.exec_en);
        end
        repeat (2) @(negedge CLKin);
        vectors++;
        if ({halted, pc, retired} !== {1'b1, 8'h01, 16'd1}) begin
            miscompares++;
            $display("FAIL drop_idle: halted=%0b pc=%0h ret=%0d required 1/1/1", halted, pc, retired);
        end
        n = 0;
        repeat (6) begin @(negedge CLKin); if (bus.exec_en === 1'b1) n++; end
        vectors++;
        if (n != 0) begin
            miscompares++; $display("FAIL drop_stays: execs=%0d required 0", n);
        end
    endtask

    initial begin
        bus.zero_a = 1'b1;
        bus.zero_s = 1'b1;
        fill_mem(8'h70);
        test_reset();
        test_free_run();
        test_random_program();
        test_skip();
        test_single_step();
        test_pc_wrap();
        test_reset_mid();
        test_run_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
